dma_ram: RTL
============

DMA_RAM -- requirements
Module: dma_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 128, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles (legal 1..4).
REQ-004 SHALL have parameter RDW_NEW, default 0, read-during-write mode (0 old data, 1 new data).
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have ports WrEn in 1, WrAddr in 32, WrData in DATA_W, WrBe in DATA_W/8, WrRdy out 1: write request, word address, data, byte enables, ready.
REQ-008 SHALL have ports RdEn in 1, RdAddr in 32, RdRdy out 1: read request, word address, ready.
REQ-009 SHALL have ports RdValid out 1, RdData out DATA_W, RdReady in 1: read response handshake.
REQ-010 SHALL have ports Busy out 1 (init in progress), AddrErr out 1 (sticky), ErrClr in 1.

Function
REQ-011 SHALL run a two-state FSM, INIT and READY; reset enters INIT.
REQ-012 SHALL, in INIT, write zero to one word per cycle at addresses 0..DEPTH-1, then enter READY; Busy=1 exactly DEPTH cycles.
REQ-013 SHALL hold WrRdy=0 and RdRdy=0 in INIT.
REQ-014 SHALL accept a write when WrEn && WrRdy; WrRdy=1 throughout READY.
REQ-015 SHALL update only bytes whose WrBe bit is 1; byte i maps to WrData[8i+7:8i].
REQ-016 SHALL define stall = RdValid && !RdReady, and RdRdy = READY && !stall.
REQ-017 SHALL accept a read when RdEn && RdRdy and present its data RD_LAT cycles later with RdValid=1, absent stall.
REQ-018 SHALL freeze the whole read pipeline while stall=1; RdData stays stable until RdReady.
REQ-019 SHALL return responses in request order; none dropped or duplicated.
REQ-020 SHALL, on a same-cycle write and read to one address, return pre-write data if RDW_NEW=0 and byte-merged post-write data if RDW_NEW=1.
REQ-021 SHALL treat address >= DEPTH (bits 31:ADDR_W nonzero) as out-of-range: write dropped, read returns zero, AddrErr set next cycle.
REQ-022 SHALL clear AddrErr on ErrClr; a same-cycle new error takes priority (AddrErr stays 1).
REQ-023 SHALL give a write accepted during a stall effect on reads accepted afterwards only.

Reset
REQ-024 SHALL on rst drive RdValid=0, RdData=0, AddrErr=0, WrRdy=0, RdRdy=0, Busy=1 next cycle; pipeline flushed.
REQ-025 SHALL, on rst asserted mid-INIT or mid-READY, restart INIT from address 0 and discard in-flight reads.
REQ-026 SHALL not reset memory contents by flop reset; clearing is by INIT only.

Structure
REQ-027 SHALL place the FSM state enum and legal RD_LAT bounds in shared package dma_pkg.
REQ-028 SHALL implement storage as sub-module dma_ram_core (1W1R, byte-enable, registered read); control, pipeline and error logic stay in dma_ram.
REQ-029 SHALL reject illegal RD_LAT or DATA_W at elaboration.

Verification
REQ-030 Reset, then idle -> Busy=1 for 1024 cycles, WrRdy=RdRdy=1 next cycle; read addr 5 -> 0.
REQ-031 Write addr 3 0xAA..AA WrBe all-1, then WrData 0x55..55 WrBe=0x0001 -> read addr 3 = 0xAA..AA55.
REQ-032 RD_LAT=3, reads addr 0,1,2 back-to-back, RdReady=0 for 4 cycles after first RdValid -> RdRdy=0, RdData frozen, then data 0,1,2 in order.
REQ-033 Same-cycle write 0x1234 / read addr 7 (old 0) -> 0 if RDW_NEW=0, 0x1234 if RDW_NEW=1.
REQ-034 Write addr 0x400 -> AddrErr=1 next cycle, memory unchanged; ErrClr -> AddrErr=0; read 0x400 -> 0, AddrErr=1.
REQ-035 rst asserted with 2 reads in flight -> no RdValid, INIT restarts, memory rereads 0.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and read-latency bounds for dma_ram
package dma_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } dma_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/dma_ram_core.sv
// rtl/dma_ram_core.sv - 1W1R byte-enable word storage with registered read port
module dma_ram_core #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the controller clears them by walking every word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // A same-edge write to raddr is not visible here; the controller merges it when wanted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dma_ram.sv
// rtl/dma_ram.sv - self-initialising RAM with stallable read pipeline and address error flag
module dma_ram
    import dma_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = 1,
    parameter int RDW_NEW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WrEn,
    input  logic [31:0]           WrAddr,
    input  logic [DATA_W-1:0]     WrData,
    input  logic [DATA_W/8-1:0]   WrBe,
    output logic                  WrRdy,
    input  logic                  RdEn,
    input  logic [31:0]           RdAddr,
    output logic                  RdRdy,
    output logic                  RdValid,
    output logic [DATA_W-1:0]     RdData,
    input  logic                  RdReady,
    output logic                  Busy,
    output logic                  AddrErr,
    input  logic                  ErrClr
);

    localparam int NBYTES = DATA_W / 8;

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || DATA_W < 8 || (DATA_W % 8) != 0 ||
            ADDR_W < 1 || ADDR_W > 31) begin : g_param_check
            $error("dma_ram: illegal RD_LAT, DATA_W or ADDR_W");
        end
    endgenerate

    dma_state_t state;
    dma_state_t state_next;
    logic [ADDR_W-1:0] init_addr;
    logic ready;

    logic wr_oor;
    logic rd_oor;
    logic wr_acc;
    logic rd_acc;
    logic stall;
    logic err_set;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [NBYTES-1:0]   mem_wbe;
    logic [DATA_W-1:0]   core_q;

    logic [RD_LAT:1]     pv;
    logic                s1_oor;
    logic                s1_byp;
    logic [DATA_W-1:0]   s1_wdata;
    logic [NBYTES-1:0]   s1_be;
    logic [DATA_W-1:0]   s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_addr == '1) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                ready = 1'b1;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_addr <= '0;
        end else if (state == ST_INIT) begin
            init_addr <= init_addr + ADDR_W'(1);
        end
    end

    assign Busy    = !ready;
    assign WrRdy   = ready;
    assign RdValid = pv[RD_LAT];
    assign stall   = RdValid && !RdReady;
    assign RdRdy   = ready && !stall;

    assign wr_oor  = |WrAddr[31:ADDR_W];
    assign rd_oor  = |RdAddr[31:ADDR_W];
    assign wr_acc  = WrEn && ready;
    assign rd_acc  = RdEn && RdRdy;
    assign err_set = (wr_acc && wr_oor) || (rd_acc && rd_oor);

    always_comb begin
        if (!ready) begin
            mem_we    = 1'b1;
            mem_waddr = init_addr;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else begin
            mem_we    = wr_acc && !wr_oor;
            mem_waddr = WrAddr[ADDR_W-1:0];
            mem_wdata = WrData;
            mem_wbe   = WrBe;
        end
    end

    dma_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .wbe   (mem_wbe),
        .re    (rd_acc),
        .raddr (RdAddr[ADDR_W-1:0]),
        .rdata (core_q)
    );

    // Valid bits shift only when the consumer is not holding the head response.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else if (!stall) begin
            pv[1] <= rd_acc;
            for (int k = 2; k <= RD_LAT; k++) begin
                pv[k] <= pv[k-1];
            end
        end
    end

    // Side info captured alongside the core read so the first stage can patch its data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_oor   <= 1'b0;
            s1_byp   <= 1'b0;
            s1_wdata <= '0;
            s1_be    <= '0;
        end else if (rd_acc) begin
            s1_oor   <= rd_oor;
            s1_byp   <= (RDW_NEW != 0) && wr_acc && !wr_oor && !rd_oor && (WrAddr == RdAddr);
            s1_wdata <= WrData;
            s1_be    <= WrBe;
        end
    end

    always_comb begin
        s1_data = core_q;
        if (s1_byp) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (s1_be[i]) begin
                    s1_data[8*i +: 8] = s1_wdata[8*i +: 8];
                end
            end
        end
        if (s1_oor) begin
            s1_data = '0;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign RdData = s1_data;
        end else begin : g_latn
            logic [DATA_W-1:0] pd [2:RD_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 2; k <= RD_LAT; k++) begin
                        pd[k] <= '0;
                    end
                end else if (!stall) begin
                    pd[2] <= s1_data;
                    for (int k = 3; k <= RD_LAT; k++) begin
                        pd[k] <= pd[k-1];
                    end
                end
            end

            assign RdData = pd[RD_LAT];
        end
    endgenerate

    // A new error in the same cycle outranks the clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            AddrErr <= 1'b0;
        end else if (err_set) begin
            AddrErr <= 1'b1;
        end else if (ErrClr) begin
            AddrErr <= 1'b0;
        end
    end

endmodule
